// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential requests to a
// 1-cycle-latency instruction memory and buffers returned instructions for decode.
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_addr,
    input  logic [31:0]                 imem_rdata,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [31:0]                 instr_out,
    output logic [XLEN-1:0]             instr_pc,
    output logic [XLEN-1:0]             instr_pc_plus4,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;
    logic [31:0]     r_fifo_instr [DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [CW:0]     w_used;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [XLEN-1:0] w_head_pc;

    // Credit counts the outstanding response but ignores this cycle's pop, so
    // instr_ready never reaches imem_req combinationally.
    assign w_used  = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_req   = rst & trigger & ~redirect_valid & (w_used < (CW+1)'(DEPTH));
    assign w_push  = r_inflight & ~redirect_valid;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & instr_ready;
    assign w_head_pc = r_fifo_pc[r_rd_ptr];

    assign imem_req       = w_req;
    assign imem_addr      = r_fetch_pc;
    assign instr_valid    = w_valid;
    assign instr_out      = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign instr_pc       = w_valid ? w_head_pc : '0;
    assign instr_pc_plus4 = w_valid ? (w_head_pc + XLEN'(4)) : '0;
    assign count          = r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc & ~XLEN'(3);
            r_inflight    <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, trigger, redirect_valid, instr_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr_out, instr_pc, instr_pc_plus4;
    logic [2:0]  count;

    logic        w_trigger, w_redir, w_ready, w_req, w_valid;
    logic [31:0] w_redir_pc, w_addr, w_rdata, w_instr, w_pc, w_pc4;
    logic [2:0]  w_count;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .trigger(trigger),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .count(count)
    );

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .trigger(w_trigger),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .instr_out(w_instr), .instr_pc(w_pc),
        .instr_pc_plus4(w_pc4), .count(w_count)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    // Synchronous instruction memories: data for a request appears the next cycle.
    initial imem_rdata = 32'h0;
    initial w_rdata    = 32'h0;
    always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : 32'hBAD0_BAD0;
    always @(posedge clk) w_rdata    <= w_req    ? memf(w_addr)    : 32'hBAD0_BAD0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: list of buffered PCs, fetch PC, one outstanding request.
    logic [31:0] mq[$];
    bit          m_infl = 0;
    logic [31:0] m_infl_pc = 0;
    logic [31:0] m_pc = 0;
    bit          m_req;
    bit          chk_en = 0;

    function automatic bit exp_req();
        return rst && trigger && !redirect_valid && ((mq.size() + int'(m_infl)) < DEPTH);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_infl = 0;
            m_pc   = 32'h0;
            chk_en = 1;
        end else if (redirect_valid) begin
            mq.delete();
            m_infl = 0;
            m_pc   = redirect_pc & ~32'h3;
        end else begin
            m_req = exp_req();
            if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (m_req) begin
                m_infl    = 1;
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_infl = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req",   {31'h0, imem_req}, {31'h0, exp_req()});
            chk("m_addr",  imem_addr, m_pc);
            chk("m_count", {29'h0, count}, mq.size());
            chk("m_valid", {31'h0, instr_valid}, {31'h0, mq.size() != 0});
            chk("m_instr", instr_out, (mq.size() != 0) ? memf(mq[0]) : 32'h0);
            chk("m_pc",    instr_pc, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("m_pc4",   instr_pc_plus4, (mq.size() != 0) ? mq[0] + 32'd4 : 32'h0);
            chk("no_overflow", {31'h0, count <= 3'(DEPTH)}, 32'h1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0; trigger = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0;
        w_trigger = 0; w_redir = 0; w_redir_pc = 0; w_ready = 1;
        repeat (3) tick();

        // Reset release and streaming.
        rst = 1; #1;
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        tick(); #1;
        chk("addr1", imem_addr, 32'h4);
        chk("valid_early", {31'h0, instr_valid}, 32'h0);
        tick(); #1;
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_pc", instr_pc, 32'h0);
        chk("first_pc4", instr_pc_plus4, 32'h4);
        chk("first_instr", instr_out, 32'hC0DE_0000);
        chk("addr2", imem_addr, 32'h8);
        tick(); #1;
        chk("second_pc", instr_pc, 32'h4);
        chk("second_pc4", instr_pc_plus4, 32'h8);
        repeat (5) tick();

        // Back-pressure fills the FIFO, then drains.
        instr_ready = 0;
        repeat (8) tick();
        #1;
        chk("full_count", {29'h0, count}, 32'd4);
        chk("full_req", {31'h0, imem_req}, 32'h0);
        instr_ready = 1;
        repeat (8) tick();

        // Redirect with count=2 and one response in flight; handshake this cycle too.
        redirect_valid = 1; redirect_pc = 32'h104; #1;
        chk("pre_redir_count", {29'h0, count}, 32'd2);
        chk("redir_req", {31'h0, imem_req}, 32'h0);
        tick(); redirect_valid = 0; #1;
        chk("post_redir_count", {29'h0, count}, 32'd0);
        chk("post_redir_valid", {31'h0, instr_valid}, 32'h0);
        chk("post_redir_addr", imem_addr, 32'h104);
        chk("post_redir_req", {31'h0, imem_req}, 32'h1);
        tick(); tick(); #1;
        chk("redir_head_pc", instr_pc, 32'h104);
        chk("redir_head_instr", instr_out, 32'hC1DA_0104);
        redirect_valid = 1; redirect_pc = 32'h107;
        tick(); redirect_valid = 0; #1;
        chk("unaligned_redir_addr", imem_addr, 32'h104);
        repeat (4) tick();

        // trigger dropped one cycle after a request.
        redirect_valid = 1; redirect_pc = 32'h200;
        tick(); redirect_valid = 0; #1;
        chk("trig_addr0", imem_addr, 32'h200);
        chk("trig_req0", {31'h0, imem_req}, 32'h1);
        tick(); trigger = 0; #1;
        chk("trig_off_req", {31'h0, imem_req}, 32'h0);
        chk("trig_off_addr", imem_addr, 32'h204);
        tick(); #1;
        chk("trig_off_push", {31'h0, instr_valid}, 32'h1);
        chk("trig_off_pc", instr_pc, 32'h200);
        chk("trig_off_hold", imem_addr, 32'h204);
        tick(); #1;
        chk("trig_off_empty", {31'h0, instr_valid}, 32'h0);
        tick(); trigger = 1; #1;
        chk("trig_resume_req", {31'h0, imem_req}, 32'h1);
        chk("trig_resume_addr", imem_addr, 32'h204);
        repeat (5) tick();

        // Reset mid-stream with the FIFO half full.
        instr_ready = 0;
        tick(); rst = 0; #1;
        chk("rst_mid_count", {29'h0, count}, 32'd2);
        chk("rst_mid_req", {31'h0, imem_req}, 32'h0);
        tick(); rst = 1; #1;
        chk("rst_after_count", {29'h0, count}, 32'd0);
        chk("rst_after_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_after_addr", imem_addr, 32'h0);
        instr_ready = 1;
        tick(); tick(); #1;
        chk("rst_restart_pc", instr_pc, 32'h0);
        repeat (4) tick();

        // Address wrap from RESET_PC near the top of the address space.
        w_trigger = 1; #1;
        chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        chk("wrap_req0", {31'h0, w_req}, 32'h1);
        tick(); #1;
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_addr2", w_addr, 32'h0000_0000);
        chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        chk("wrap_pc4_0", w_pc4, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", w_pc4, 32'h0000_0000);
        chk("wrap_instr1", w_instr, 32'h3F22_FFFC);
        chk("wrap_count", {29'h0, w_count}, 32'd1);
        chk("wrap_valid", {31'h0, w_valid}, 32'h1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
